// File: rtl/fpu_longop_sequencer.sv
// Issue/latency/writeback sequencer for the multi-cycle FP divide/sqrt unit.
// Also produces the structural, dependency and WB-starvation stalls for the hazard unit.
module fpu_longop_sequencer #(
    parameter int LATENCY  = 48,
    parameter int CNT_W    = 6,
    parameter int MAX_WAIT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    input  logic        issue_op,
    input  logic [4:0]  issue_rd,
    input  logic        flush,
    input  logic        longop_id,
    input  logic [4:0]  rs1_id,
    input  logic [4:0]  rs2_id,
    input  logic [4:0]  rd_id,
    input  logic        rs1_used,
    input  logic        rs2_used,
    input  logic        rd_used,
    input  logic [31:0] unit_result,
    input  logic        pipe_wb_valid,
    output logic        unit_start,
    output logic        unit_op,
    output logic        unit_abort,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        stall,
    output logic        busy,
    output logic        issue_err
);

    localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {IDLE, RUN, WB} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [WAIT_W-1:0]  wait_reg, wait_next;
    logic [4:0]         rd_reg, rd_next;
    logic               op_reg, op_next;
    logic [31:0]        result_reg, result_next;
    logic               start_reg, start_next;
    logic               abort_reg, abort_next;
    logic               err_reg, err_next;
    logic               busy_int;
    logic               dep_hit;
    logic               starve;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            wait_reg   <= '0;
            rd_reg     <= '0;
            op_reg     <= 1'b0;
            result_reg <= '0;
            start_reg  <= 1'b0;
            abort_reg  <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            wait_reg   <= wait_next;
            rd_reg     <= rd_next;
            op_reg     <= op_next;
            result_reg <= result_next;
            start_reg  <= start_next;
            abort_reg  <= abort_next;
            err_reg    <= err_next;
        end
    end

    assign busy_int = (state_reg != IDLE);

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        wait_next   = wait_reg;
        rd_next     = rd_reg;
        op_next     = op_reg;
        result_next = result_reg;
        start_next  = 1'b0;
        abort_next  = 1'b0;
        err_next    = err_reg | (issue_valid & busy_int);
        wb_valid    = 1'b0;
        case (state_reg)
            IDLE: begin
                // A flush in the same cycle kills the issuing instruction.
                if (issue_valid && !flush) begin
                    rd_next    = issue_rd;
                    op_next    = issue_op;
                    cnt_next   = '0;
                    wait_next  = '0;
                    start_next = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (flush) begin
                    cnt_next   = '0;
                    abort_next = 1'b1;
                    state_next = IDLE;
                end else if (cnt_reg == CNT_W'(LATENCY - 1)) begin
                    result_next = unit_result;
                    cnt_next    = '0;
                    wait_next   = '0;
                    state_next  = WB;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            WB: begin
                if (flush) begin
                    wait_next  = '0;
                    abort_next = 1'b1;
                    state_next = IDLE;
                end else if (!pipe_wb_valid) begin
                    wb_valid   = 1'b1;
                    wait_next  = '0;
                    state_next = IDLE;
                end else if (wait_reg < WAIT_W'(MAX_WAIT)) begin
                    wait_next = wait_reg + WAIT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // f0 is a real FP register, so no zero-register exclusion on the match.
    assign dep_hit = (rs1_used && (rs1_id == rd_reg)) ||
                     (rs2_used && (rs2_id == rd_reg)) ||
                     (rd_used  && (rd_id  == rd_reg));

    assign starve = (state_reg == WB) && (wait_reg >= WAIT_W'(MAX_WAIT));

    assign stall      = (busy_int && (longop_id || dep_hit)) || starve;
    assign busy       = busy_int;
    assign unit_start = start_reg;
    assign unit_abort = abort_reg;
    assign unit_op    = op_reg;
    assign issue_err  = err_reg;
    assign wb_rd      = rd_reg;
    assign wb_data    = result_reg;

endmodule

// File: tb/tb_fpu_longop_sequencer.sv
// Directed bench for fpu_longop_sequencer; writebacks are checked against a
// scoreboard of {rd, data, cycle} pushed when each accepted op is issued.
module tb_fpu_longop_sequencer;

    localparam int LATENCY  = 48;
    localparam int CNT_W    = 6;
    localparam int MAX_WAIT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid, issue_op, flush, longop_id;
    logic [4:0]  issue_rd, rs1_id, rs2_id, rd_id;
    logic        rs1_used, rs2_used, rd_used, pipe_wb_valid;
    logic [31:0] unit_result;
    logic        unit_start, unit_op, unit_abort, wb_valid, stall, busy, issue_err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int wb_count = 0;
    int wb_snap;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t sb_q[$];
    exp_t sb_e;

    fpu_longop_sequencer #(.LATENCY(LATENCY), .CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_op(issue_op), .issue_rd(issue_rd),
        .flush(flush), .longop_id(longop_id),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id),
        .rs1_used(rs1_used), .rs2_used(rs2_used), .rd_used(rd_used),
        .unit_result(unit_result), .pipe_wb_valid(pipe_wb_valid),
        .unit_start(unit_start), .unit_op(unit_op), .unit_abort(unit_abort),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .stall(stall), .busy(busy), .issue_err(issue_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Unit output changes every cycle so a capture in the wrong cycle is visible.
    function automatic logic [31:0] res_f(input int c);
        logic [31:0] t;
        t = c;
        return 32'h5EED_0001 ^ (t * 32'h9E37_79B9);
    endfunction

    assign unit_result = res_f(cyc);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic to_cycle(input int c);
        while (cyc < c) next_cycle();
    endtask

    task automatic push_op(input logic [4:0] rd, input int issue_cyc, input int lost);
        exp_t e;
        e.rd   = rd;
        e.data = res_f(issue_cyc + LATENCY);
        e.cyc  = issue_cyc + LATENCY + 1 + lost;
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (wb_valid === 1'b1) begin
            wb_count++;
            checks++;
            assert (sb_q.size() > 0) else begin
                failures++;
                $error("FAIL wb_unexpected observed=wb_valid expected=no_write cycle=%0d", cyc);
            end
            if (sb_q.size() > 0) begin
                sb_e = sb_q.pop_front();
                chk("sb_rd", 32'(wb_rd), 32'(sb_e.rd));
                chk("sb_data", wb_data, sb_e.data);
                chk("sb_cycle", cyc, sb_e.cyc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        issue_valid = 1'b0; issue_op = 1'b0; issue_rd = '0; flush = 1'b0;
        longop_id = 1'b0; rs1_id = '0; rs2_id = '0; rd_id = '0;
        rs1_used = 1'b0; rs2_used = 1'b0; rd_used = 1'b0; pipe_wb_valid = 1'b0;

        // Reset state
        to_cycle(2);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_wb_valid", 32'(wb_valid), 0);
        chk("rst_start", 32'(unit_start), 0);
        chk("rst_abort", 32'(unit_abort), 0);
        chk("rst_err", 32'(issue_err), 0);
        chk("rst_wb_data", wb_data, 0);
        to_cycle(3);
        rst = 1'b0;

        // fdiv rd=5, dependent rs2 in ID
        to_cycle(10);
        issue_valid = 1'b1; issue_op = 1'b0; issue_rd = 5'd5;
        rs2_id = 5'd5; rs2_used = 1'b1;
        push_op(5'd5, 10, 0);
        @(negedge clk);
        chk("A_stall_pre", 32'(stall), 0);
        to_cycle(11);
        issue_valid = 1'b0;
        @(negedge clk);
        chk("A_start", 32'(unit_start), 1);
        chk("A_busy", 32'(busy), 1);
        chk("A_dep_stall", 32'(stall), 1);
        chk("A_op", 32'(unit_op), 0);
        to_cycle(12);
        @(negedge clk);
        chk("A_start_pulse", 32'(unit_start), 0);
        to_cycle(13);
        rs2_used = 1'b0; rs1_id = 5'd6; rs1_used = 1'b1;
        @(negedge clk);
        chk("A_rs1_nodep", 32'(stall), 0);
        to_cycle(14);
        rs1_used = 1'b0; rs2_used = 1'b1;
        to_cycle(58);
        @(negedge clk);
        chk("A_wb_early", 32'(wb_valid), 0);
        to_cycle(59);
        @(negedge clk);
        chk("A_wb", 32'(wb_valid), 1);
        chk("A_stall_wb", 32'(stall), 1);
        to_cycle(60);
        @(negedge clk);
        chk("A_busy_done", 32'(busy), 0);
        chk("A_stall_done", 32'(stall), 0);
        rs2_used = 1'b0;

        // fsqrt rd=7, structural stall and ignored issue while busy
        to_cycle(70);
        issue_valid = 1'b1; issue_op = 1'b1; issue_rd = 5'd7;
        push_op(5'd7, 70, 0);
        to_cycle(71);
        issue_valid = 1'b0; longop_id = 1'b1;
        @(negedge clk);
        chk("B_struct_stall", 32'(stall), 1);
        chk("B_op", 32'(unit_op), 1);
        to_cycle(75);
        issue_valid = 1'b1; issue_rd = 5'd9;
        @(negedge clk);
        chk("B_err_pre", 32'(issue_err), 0);
        to_cycle(76);
        issue_valid = 1'b0;
        @(negedge clk);
        chk("B_err", 32'(issue_err), 1);
        chk("B_no_restart", 32'(unit_start), 0);
        to_cycle(119);
        @(negedge clk);
        chk("B_wb", 32'(wb_valid), 1);
        chk("B_stall_wb", 32'(stall), 1);
        to_cycle(120);
        @(negedge clk);
        chk("B_stall_done", 32'(stall), 0);
        chk("B_err_sticky", 32'(issue_err), 1);
        longop_id = 1'b0;

        // Writeback starvation: pipeline holds the port for 3 cycles
        to_cycle(130);
        issue_valid = 1'b1; issue_op = 1'b0; issue_rd = 5'd12;
        push_op(5'd12, 130, 3);
        to_cycle(131);
        issue_valid = 1'b0;
        to_cycle(178);
        pipe_wb_valid = 1'b1;
        to_cycle(179);
        @(negedge clk);
        chk("C_lost1_stall", 32'(stall), 0);
        chk("C_lost1_wb", 32'(wb_valid), 0);
        to_cycle(180);
        @(negedge clk);
        chk("C_lost2_stall", 32'(stall), 0);
        to_cycle(181);
        @(negedge clk);
        chk("C_starve_stall", 32'(stall), 1);
        chk("C_starve_wb", 32'(wb_valid), 0);
        to_cycle(182);
        pipe_wb_valid = 1'b0;
        @(negedge clk);
        chk("C_wb", 32'(wb_valid), 1);
        chk("C_stall_wb", 32'(stall), 1);
        to_cycle(183);
        @(negedge clk);
        chk("C_stall_done", 32'(stall), 0);
        chk("C_busy_done", 32'(busy), 0);

        // Flush at cnt=20, then flush with a simultaneous issue
        wb_snap = wb_count;
        to_cycle(190);
        issue_valid = 1'b1; issue_rd = 5'd3;
        to_cycle(191);
        issue_valid = 1'b0; rs1_id = 5'd3; rs1_used = 1'b1;
        to_cycle(211);
        flush = 1'b1;
        @(negedge clk);
        chk("D_stall_flush", 32'(stall), 1);
        chk("D_abort_pre", 32'(unit_abort), 0);
        to_cycle(212);
        flush = 1'b0;
        @(negedge clk);
        chk("D_abort", 32'(unit_abort), 1);
        chk("D_busy", 32'(busy), 0);
        chk("D_stall_drop", 32'(stall), 0);
        to_cycle(213);
        @(negedge clk);
        chk("D_abort_pulse", 32'(unit_abort), 0);
        rs1_used = 1'b0;
        to_cycle(215);
        issue_valid = 1'b1; flush = 1'b1; issue_rd = 5'd4;
        to_cycle(216);
        issue_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("D_flush_issue_start", 32'(unit_start), 0);
        chk("D_flush_issue_busy", 32'(busy), 0);
        to_cycle(250);
        @(negedge clk);
        chk("D_no_wb", wb_count, wb_snap);

        // Reset at cnt=30, then a normal op
        to_cycle(260);
        issue_valid = 1'b1; issue_op = 1'b1; issue_rd = 5'd20;
        to_cycle(261);
        issue_valid = 1'b0;
        to_cycle(291);
        rd_id = 5'd20; rd_used = 1'b1;
        @(negedge clk);
        chk("E_waw_stall", 32'(stall), 1);
        rst = 1'b1;
        #1;
        chk("E_rst_busy", 32'(busy), 0);
        chk("E_rst_stall", 32'(stall), 0);
        chk("E_rst_op", 32'(unit_op), 0);
        chk("E_rst_rd", 32'(wb_rd), 0);
        chk("E_rst_data", wb_data, 0);
        chk("E_rst_err", 32'(issue_err), 0);
        to_cycle(292);
        rst = 1'b0; rd_used = 1'b0;
        to_cycle(300);
        issue_valid = 1'b1; issue_op = 1'b0; issue_rd = 5'd21;
        push_op(5'd21, 300, 0);
        to_cycle(301);
        issue_valid = 1'b0;
        @(negedge clk);
        chk("E_start", 32'(unit_start), 1);
        to_cycle(350);
        @(negedge clk);
        chk("E_busy_done", 32'(busy), 0);
        chk("sb_empty", 32'(sb_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fpu_longop_sequencer.md
# fpu_longop_sequencer

Sequencer for the multi-cycle FP divide/sqrt unit in the RISC-V pipeline. Accepts a long-latency FP op issued from EX, starts the unit, counts its fixed latency, and captures the result. It then arbitrates the FP register-file write port against the normal pipeline writeback. It also generates the structural, dependency and writeback-starvation stalls that the hazard detection unit ORs into PC/IF-ID hold and control zeroing.

## Interface
Parameters:
- LATENCY, 48, unit cycles from start to valid result (≥2)
- CNT_W, 6, counter width; must satisfy 2^CNT_W ≥ LATENCY
- MAX_WAIT, 2, WB cycles lost to the pipeline before forcing a freeze

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- issue_valid  in  1  long op (fdiv/fsqrt) in EX this cycle
- issue_op  in  1  0 = div, 1 = sqrt
- issue_rd  in  5  FP destination register
- flush  in  1  kill in-flight long op (mispredict/exception)
- longop_id  in  1  decoded long op sitting in ID
- rs1_id, rs2_id, rd_id  in  5 each  FP register fields in ID
- rs1_used, rs2_used, rd_used  in  1 each  field valid as FP reg
- unit_result  in  32  unit output, valid in cycle LATENCY after start
- pipe_wb_valid  in  1  pipeline writing FP reg file this cycle
- unit_start  out  1  one-cycle start pulse
- unit_op  out  1  latched op
- unit_abort  out  1  one-cycle abort pulse on flush
- wb_valid  out  1  write long-op result this cycle
- wb_rd  out  5  destination
- wb_data  out  32  result
- stall  out  1  to hazard unit (hold PC, IF/ID, zero control)
- busy  out  1  state ≠ IDLE
- issue_err  out  1  sticky: issue_valid seen while busy

## Operation
- States: IDLE, RUN, WB.
- IDLE:
  - On issue_valid & !flush: latch rd/op, cnt←0, state←RUN, unit_start=1 next cycle.
  - On issue_valid & flush: ignored; flush wins.
- RUN:
  - cnt increments each cycle.
  - At cnt==LATENCY-1: capture unit_result into result_q, state←WB.
- WB:
  - wb_req pending, wait←wait+1 per lost cycle.
  - If !pipe_wb_valid: wb_valid=1 with wb_rd/wb_data, state←IDLE.
  - If pipe_wb_valid: pipeline has priority; stay in WB.
  - When wait ≥ MAX_WAIT: assert stall. Pipeline then drains and pipe_wb_valid falls; write completes.
- Stall sources (combinational, OR'd):
  - structural: longop_id & busy
  - dependency: busy & ((rs1_used & rs1_id==pend_rd) | (rs2_used & rs2_id==pend_rd) | (rd_used & rd_id==pend_rd)), covering RAW and WAW
  - starvation: state==WB & wait ≥ MAX_WAIT
- flush in RUN or WB:
  - state←IDLE, cnt/wait←0, unit_abort pulse next cycle, no writeback.
  - Stall drops the next cycle.
- issue_valid while busy: ignored, issue_err←1 until reset.
- pend_rd comparison includes f0; FP f0 is a real register.

## Timing
- Reset values: all outputs 0, state IDLE, cnt 0, wait 0, result_q 0, issue_err 0.
- Issue sampled at edge T:
  - unit_start high in cycle T+1
  - capture at end of cycle T+LATENCY
  - earliest wb_valid in cycle T+LATENCY+1
- wb_valid is high exactly one cycle per op.
- Dependency stall stays high in the wb_valid cycle (register-file write at edge, no bypass). It drops the following cycle.
- unit_start and unit_abort are registered single-cycle pulses, never simultaneous.
- Reset mid-op: immediate IDLE, no pulses, no writeback.
- cnt never exceeds LATENCY-1. wait saturates at MAX_WAIT.

## Test plan
- fdiv issue_rd=5 at cycle 10, LATENCY=48, pipe_wb_valid=0 -> unit_start at 11, wb_valid at 59 with wb_rd=5 and wb_data = unit_result sampled at 58, busy low at 60.
- After fdiv rd=5, ID reads rs2_id=5 (rs2_used) -> stall high from issue+1 through wb cycle, low the cycle after. rs1_id=6 -> no stall.
- Second longop_id while RUN -> stall held until wb completes. Forced issue_valid while busy -> ignored, issue_err=1.
- pipe_wb_valid held high in WB, MAX_WAIT=2 -> stall rises after 2 lost cycles. Release pipe_wb_valid -> wb_valid that cycle, stall low next.
- flush at cnt=20 -> unit_abort pulse next cycle, no wb_valid, busy 0. Flush with simultaneous issue -> no unit_start.
- rst asserted at cnt=30 -> all outputs 0 immediately. New issue after release -> normal latency.
